// File: rtl/concat_packer_if.sv
// Purpose: handshake bundle for concat_packer: a narrow field stream in
// (valid/ready plus flush) and a packed wide word stream out (valid/ready).
// Ports (signals):
//   in_data / in_valid / in_ready : field stream into the packer
//   flush                         : close the current partial word
//   out_data / out_count          : packed word and its number of valid fields
//   out_valid / out_ready         : word stream out of the packer
// Modports: slave = packer side, master = producer/consumer side.
interface concat_packer_if #(
  parameter int unsigned FIELD_W    = 2,
  parameter int unsigned NUM_FIELDS = 4
);
  localparam int unsigned DATA_W = FIELD_W * NUM_FIELDS;
  localparam int unsigned CNT_W  = $clog2(NUM_FIELDS + 1);

  logic [FIELD_W-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [DATA_W-1:0]  out_data;
  logic [CNT_W-1:0]   out_count;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_count, out_valid
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_count, out_valid
  );
endinterface

// File: rtl/concat_packer.sv
// Purpose: packs NUM_FIELDS narrow fields into one wide registered word,
// MSB-first or LSB-first, with flush to emit a partially filled word.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : concat_packer_if.slave (field stream in, packed word stream out)
module concat_packer #(
  parameter int unsigned FIELD_W    = 2,
  parameter int unsigned NUM_FIELDS = 4,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  concat_packer_if.slave         bus
);
  localparam int unsigned DATA_W = FIELD_W * NUM_FIELDS;
  localparam int unsigned CNT_W  = $clog2(NUM_FIELDS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_FIELDS);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              closed_q, closed_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_valid_q, out_valid_d;

  logic              complete;
  logic              slot_free;
  logic              xfer;
  logic              in_ready_c;
  logic              accept;
  logic [CNT_W-1:0]  base_cnt;

  // Handshake qualifiers; in_ready may combinationally follow out_ready.
  always_comb begin
    complete   = (cnt_q == FULL) || (closed_q && (cnt_q != '0));
    slot_free  = !out_valid_q || bus.out_ready;
    xfer       = complete && slot_free;
    in_ready_c = !complete || slot_free;
    accept     = bus.in_valid && in_ready_c;
    base_cnt   = xfer ? '0 : cnt_q;
  end

  // Next-state: accumulator restart on transfer, field insert, flush close.
  always_comb begin
    acc_d       = xfer ? '0 : acc_q;
    cnt_d       = base_cnt + CNT_W'(accept);
    closed_d    = xfer ? 1'b0 : closed_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;

    // Slot k of a word sits at the top for MSB-first, at the bottom otherwise.
    for (int unsigned s = 0; s < NUM_FIELDS; s++) begin
      if (accept && (base_cnt == CNT_W'(s))) begin
        acc_d[(MSB_FIRST ? (NUM_FIELDS - 1 - s) : s) * FIELD_W +: FIELD_W] = bus.in_data;
      end
    end

    // A flush only closes a word that is still open and non-empty afterwards.
    if (bus.flush && !complete && (cnt_d != '0) && (cnt_d != FULL)) begin
      closed_d = 1'b1;
    end

    if (xfer) begin
      out_data_d  = acc_q;
      out_count_d = cnt_q;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      closed_q    <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      closed_q    <= closed_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: doc/concat_packer.md
# concat_packer

Registered, parametrised field concatenator for the ice40 architecture suite. It accepts a stream of narrow `FIELD_W`-bit fields over a valid/ready handshake and packs `NUM_FIELDS` of them into one wide word, in MSB-first or LSB-first concatenation order. A `flush` request emits a partially filled word. It exercises LUT/DFF packing of wide concatenations, mux trees and handshake logic, where a purely combinational concat block exercises none of these.

## Interface
- `FIELD_W`, 2, width of one input field (≥1)
- `NUM_FIELDS`, 4, fields per output word (≥2)
- `MSB_FIRST`, 1, 1: first accepted field lands in the top slot; 0: first field lands in bits [FIELD_W-1:0]
- `CNT_W`, derived `$clog2(NUM_FIELDS+1)`, local parameter, not overridable

Ports:
- `clk`  input  1  sole clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `in_data`  input  FIELD_W  field payload
- `in_valid`  input  1  field offered
- `in_ready`  output  1  field accepted when `in_valid && in_ready` at a rising edge
- `flush`  input  1  close the current partial word
- `out_data`  output  FIELD_W*NUM_FIELDS  packed word, registered
- `out_count`  output  CNT_W  number of valid fields in `out_data` (1..NUM_FIELDS), registered
- `out_valid`  output  1  word offered, registered
- `out_ready`  input  1  word consumed when `out_valid && out_ready` at a rising edge

## Operation
- State:
  - accumulator `acc` (FIELD_W*NUM_FIELDS bits)
  - fill count `cnt` (0..NUM_FIELDS)
  - `closed` flag
  - output register (`out_data`, `out_count`, `out_valid`)
- Slot index for the k-th field of a word (k = 0..NUM_FIELDS-1):
  - MSB_FIRST=1: bits [(NUM_FIELDS-k)*FIELD_W-1 -: FIELD_W]
  - MSB_FIRST=0: bits [k*FIELD_W +: FIELD_W]
  - Unfilled slots are 0.
- `complete = (cnt == NUM_FIELDS) || (closed && cnt != 0)`.
- `slot_free = !out_valid || out_ready`.
- `xfer = complete && slot_free`. On `xfer`:
  - `out_data <= acc`, `out_count <= cnt`, `out_valid <= 1`
  - accumulator restarts: `acc` is cleared, `cnt` goes to 0 (or to 1 if a field is accepted the same edge), `closed` goes to 0
- `in_ready = !complete || slot_free` (combinational path from `out_ready` is allowed).
- An accepted field is written at slot `xfer ? 0 : cnt`, and `cnt` increments from that base.
- `out_valid` clears on a consume edge without `xfer`. On consume with `xfer`, the output register reloads and `out_valid` stays 1.
- Flush rules:
  - `flush` is sampled at the rising edge.
  - If a field is accepted on the same edge, that field is included before the word closes.
  - `flush` sets `closed` only when the post-edge `cnt` is 1..NUM_FIELDS-1.
  - `flush` with `cnt` = 0 and no accepted field is ignored.
  - `flush` on an already complete word is ignored.
- `flush` and `in_valid` may be held high across cycles. Each edge is evaluated independently.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_count`=0
  - `acc`=0, `cnt`=0, `closed`=0
  - `in_ready`=1 while `rst` is deasserted
- `rst` mid-word discards the partial word and any held output word. No output is produced for it.
- Latency: the edge that accepts the last field, or the flush edge, sets `complete`. `out_valid` rises on the next edge if `slot_free`, so the word appears 1 cycle after the final accept.
- Throughput: with `out_ready` held at 1 and `in_valid` continuous, one field is accepted every cycle with no bubbles, giving one word per NUM_FIELDS cycles.
- Backpressure:
  - With `out_valid`=1 and `out_ready`=0, the accumulator keeps filling until `cnt`=NUM_FIELDS.
  - `in_ready` then drops to 0 and holds until `out_ready` is seen.
- `out_data` and `out_count` are stable while `out_valid && !out_ready`.

## Test plan
- Defaults, `out_ready`=1; fields 1,2,3,0 on consecutive cycles -> one cycle after the 4th accept: `out_valid`=1, `out_data`=8'h6C, `out_count`=4.
- MSB_FIRST=0, same stimulus -> `out_data`=8'h39, `out_count`=4.
- Fields 3,1 then a `flush` pulse -> `out_data`=8'hD0, `out_count`=2. A following field 2 starts a new word at the top slot.
- `flush` on the same edge as a 3rd field 2 after 3,1 -> `out_data`=8'hD8, `out_count`=3. A `flush` pulse with `cnt`=0 -> no output.
- `out_ready`=0, 10 fields offered continuously:
  - word 0 is held, and 4 more fields are accepted before `in_ready`=0
  - raising `out_ready` for one cycle delivers word 1 to the output register on that same edge, with no lost or duplicated field
- `rst` asserted asynchronously after 2 fields, mid-cycle -> outputs zero immediately. After release, fields 1,1,1,1 -> `out_data`=8'h55.
